alu_op_sequencer: RTL and testbench

//  Initiator side of the 8-bit ALU command interface. Accepts one operation request
//  (opcode index + operands) over a valid/ready channel and encodes the index to the ALU sel code.

---
 rtl/alu_op_sequencer_if.sv | 25 ++
 rtl/alu_op_sequencer.sv | 88 ++++++++
 tb/tb_alu_op_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request/response channel bundle between an operation producer and alu_op_sequencer.
// The sequencer takes the slave side; the producer/consumer takes the master side.
interface alu_op_sequencer_if #(
  parameter int unsigned DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time: accepts a request, drives the external combinational
// ALU, captures its result and returns it on a response channel, screening illegal ops and /0.
module alu_op_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  alu_op_sequencer_if.slave bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_y,
  output logic [CNT_W-1:0]  ops_done
);

  typedef enum logic [1:0] {StIdle, StDrive, StCapture, StResp} state_e;

  state_e     state_q;
  logic       err_q;
  logic [3:0] enc_sel;
  logic       req_err;

  always_comb begin
    enc_sel = 4'b0000;
    unique case (bus.req_op)
      4'd0:    enc_sel = 4'b0001;
      4'd1:    enc_sel = 4'b0011;
      4'd2:    enc_sel = 4'b0101;
      4'd3:    enc_sel = 4'b1001;
      4'd4:    enc_sel = 4'b0111;
      4'd5:    enc_sel = 4'b1101;
      4'd6:    enc_sel = 4'b1011;
      4'd7:    enc_sel = 4'b0010;
      4'd8:    enc_sel = 4'b1111;
      default: enc_sel = 4'b0000;
    endcase
    // Errored ops park the ALU on sel 0000 so a divide by zero is never presented.
    req_err = (bus.req_op > 4'd8) || ((bus.req_op == 4'd3) && (bus.req_b == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      err_q         <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_sel       <= 4'b0000;
      ops_done      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            alu_a         <= bus.req_a;
            alu_b         <= bus.req_b;
            alu_sel       <= req_err ? 4'b0000 : enc_sel;
            err_q         <= req_err;
            bus.req_ready <= 1'b0;
            state_q       <= StDrive;
          end
        end
        StDrive: begin
          bus.rsp_data <= err_q ? '0 : alu_y;
          state_q      <= StCapture;
        end
        StCapture: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= err_q;
          state_q       <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            ops_done      <= ops_done + {{(CNT_W-1){1'b0}}, 1'b1};
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed cases plus randomized ops against a
// behavioural model of the operation semantics, with a behavioural ALU on the alu_* port.
module tb_alu_op_sequencer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 2;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_sel;
  logic [DATA_W-1:0] alu_y;
  logic [CNT_W-1:0]  ops_done;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  alu_op_sequencer_if #(.DATA_W(DATA_W)) bus ();

  alu_op_sequencer #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_sel (alu_sel),
    .alu_y   (alu_y),
    .ops_done(ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the team ALU, keyed on its sel codes.
  always_comb begin
    alu_y = '0;
    case (alu_sel)
      4'b0001: alu_y = alu_a + alu_b;
      4'b0011: alu_y = alu_a - alu_b;
      4'b0101: alu_y = alu_a * alu_b;
      4'b1001: alu_y = (alu_b != 0) ? alu_a / alu_b : 8'hEE;
      4'b0111: alu_y = alu_a << alu_b;
      4'b1101: alu_y = alu_a >> alu_b;
      4'b1011: alu_y = alu_a & alu_b;
      4'b0010: alu_y = alu_a | alu_b;
      4'b1111: alu_y = (alu_a == alu_b) ? 8'd1 : 8'd0;
      default: alu_y = 8'h5A;
    endcase
  end

  function automatic logic [3:0] ref_sel(input int op);
    logic [3:0] tab [9];
    tab = '{4'b0001, 4'b0011, 4'b0101, 4'b1001, 4'b0111, 4'b1101, 4'b1011, 4'b0010, 4'b1111};
    return tab[op];
  endfunction

  function automatic logic [7:0] ref_result(input int op, input int a, input int b);
    int r;
    r = 0;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a * b;
      3: r = a / b;
      4: r = (b >= 8) ? 0 : a * (1 << b);
      5: r = (b >= 8) ? 0 : a / (1 << b);
      6: r = a & b;
      7: r = a | b;
      8: r = (a == b) ? 1 : 0;
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_ops_done", 32'(ops_done), 32'd0);
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge after the response
  // handshake, which is also the earliest slot for the next accept.
  task automatic run_op(input int op, input int a, input int b, input int hold);
    logic       err;
    logic [7:0] res;
    logic [3:0] sel;
    err = (op > 8) || (op == 3 && b == 0);
    res = err ? 8'h00 : ref_result(op, a, b);
    sel = err ? 4'b0000 : ref_sel(op);
    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = 4'(op);
    bus.req_a     = 8'(a);
    bus.req_b     = 8'(b);
    @(negedge clk);
    // Garbage request held valid while busy must be ignored.
    bus.req_op = 4'($urandom);
    bus.req_a  = 8'($urandom);
    bus.req_b  = 8'($urandom);
    chk("drive_alu_sel", 32'(alu_sel), 32'(sel));
    chk("drive_alu_a", 32'(alu_a), 32'(a[7:0]));
    chk("drive_alu_b", 32'(alu_b), 32'(b[7:0]));
    chk("drive_req_ready", 32'(bus.req_ready), 32'd0);
    chk("drive_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("capture_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("resp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("resp_rsp_data", 32'(bus.rsp_data), 32'(res));
    chk("resp_rsp_err", 32'(bus.rsp_err), 32'(err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rsp_data", 32'(bus.rsp_data), 32'(res));
      chk("hold_rsp_err", 32'(bus.rsp_err), 32'(err));
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      chk("hold_ops_done", 32'(ops_done), 32'(exp_cnt));
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    chk("done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("done_req_ready", 32'(bus.req_ready), 32'd1);
    chk("done_ops_done", 32'(ops_done), 32'(exp_cnt));
    chk("done_alu_sel_held", 32'(alu_sel), 32'(sel));
  endtask

  initial begin
    int op;
    int a;
    int b;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_state();

    // ADD, divide by zero, legal DIV, illegal op.
    run_op(0, 8'h12, 8'h34, 0);
    run_op(3, 8'h40, 8'h00, 0);
    run_op(3, 8'h40, 8'h08, 1);
    run_op(4'hA, 8'h33, 8'h44, 0);
    // Backpressure: response held for five cycles.
    run_op(0, 8'hF0, 8'h20, 5);

    // Reset while in DRIVE aborts the op.
    bus.req_valid = 1'b1;
    bus.req_op    = 4'd0;
    bus.req_a     = 8'h11;
    bus.req_b     = 8'h22;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    rst           = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    chk_reset_state();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("abort_ops_done", 32'(ops_done), 32'd0);
    end
    bus.rsp_ready = 1'b0;

    // Back-to-back ops with the 2-bit counter wrapping: 1,2,3,0,1.
    run_op(2, 8'h10, 8'h11, 0);
    run_op(8, 8'h05, 8'h05, 0);
    run_op(4, 8'h01, 8'h03, 0);
    run_op(5, 8'h80, 8'h07, 0);
    run_op(7, 8'hA0, 8'h05, 0);

    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 3 : int'($urandom_range(0, 15));
      a  = int'($urandom_range(0, 255));
      b  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 255));
      if (op == 4 || op == 5) b = int'($urandom_range(0, 9));
      run_op(op, a, b, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
